// File: rtl/taxi_meter_pkg.sv
// taxi_meter_pkg: state encoding, default parameters and saturating add for the taxi meter
package taxi_meter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  localparam int DEF_W = 16;
  localparam int DEF_BASE_FARE = 5;
  localparam int DEF_BASE_DIST = 3;
  localparam int DEF_KM_RATE = 2;
  localparam int DEF_WAIT_RATE = 1;
  localparam int DEF_PULSES_PER_UNIT = 10;
  localparam int DEF_TICKS_PER_MIN = 60;
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input logic [63:0] lim);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[63:0];
  endfunction
endpackage

// File: rtl/taxi_meter_if.sv
// taxi_meter_if: control strobes and trip outputs of the taxi meter
// Build option TAXI_NIGHT_SURCHARGE_EN adds the night input.
interface taxi_meter_if import taxi_meter_pkg::*; #(parameter int W = DEF_W);
  logic start, stop, clear, halted, wheel_pulse, sec_tick;
`ifdef TAXI_NIGHT_SURCHARGE_EN
  logic night;
`endif
  logic [W-1:0] distance, minute, fare;
  state_t state;
  logic fare_valid;
  modport master (
`ifdef TAXI_NIGHT_SURCHARGE_EN
    output night,
`endif
    output start, stop, clear, halted, wheel_pulse, sec_tick,
    input distance, minute, fare, state, fare_valid
  );
  modport slave (
`ifdef TAXI_NIGHT_SURCHARGE_EN
    input night,
`endif
    input start, stop, clear, halted, wheel_pulse, sec_tick,
    output distance, minute, fare, state, fare_valid
  );
endinterface

// File: rtl/taxi_fare_calc.sv
// taxi_fare_calc: registered, saturating fare from distance and waiting minutes, with optional +50% night rate
module taxi_fare_calc import taxi_meter_pkg::*; #(
  parameter int W = DEF_W,
  parameter int BASE_FARE = DEF_BASE_FARE,
  parameter int BASE_DIST = DEF_BASE_DIST,
  parameter int KM_RATE = DEF_KM_RATE,
  parameter int WAIT_RATE = DEF_WAIT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic night,
  input  logic [W-1:0] distance,
  input  logic [W-1:0] minute,
  output logic [W-1:0] fare
);
  localparam int FW = 2 * W + 2;
  localparam logic [63:0] MAX = 64'((65'd1 << W) - 65'd1);
  logic [FW-1:0] d, m, km, base;
  logic [W-1:0] sat, nxt;
  always_comb begin
    d = FW'(distance);
    m = FW'(minute);
    km = (d >= FW'(BASE_DIST)) ? FW'(KM_RATE) * (d - FW'(BASE_DIST)) : '0;
    base = FW'(BASE_FARE) + km + FW'(WAIT_RATE) * m;
    // Saturating before the surcharge is exact: a saturated base stays saturated after +50%.
    sat = W'(sat_add(64'(base), 64'd0, MAX));
    nxt = night ? W'(sat_add(64'(sat), 64'(sat >> 1), MAX)) : sat;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fare <= '0;
    else fare <= clr ? '0 : nxt;
endmodule

// File: rtl/taxi_meter_core.sv
// taxi_meter_core: trip FSM, distance/minute prescalers and counters, registered fare
// Build option TAXI_NIGHT_SURCHARGE_EN latches a night flag at trip start for a +50% fare.
module taxi_meter_core import taxi_meter_pkg::*; #(
  parameter int W = DEF_W,
  parameter int BASE_FARE = DEF_BASE_FARE,
  parameter int BASE_DIST = DEF_BASE_DIST,
  parameter int KM_RATE = DEF_KM_RATE,
  parameter int WAIT_RATE = DEF_WAIT_RATE,
  parameter int PULSES_PER_UNIT = DEF_PULSES_PER_UNIT,
  parameter int TICKS_PER_MIN = DEF_TICKS_PER_MIN
) (
  input logic clk,
  input logic rst_n,
  taxi_meter_if.slave bus
);
  localparam int PW = $clog2(PULSES_PER_UNIT + 1);
  localparam int TW = $clog2(TICKS_PER_MIN + 1);
  localparam logic [63:0] MAX = 64'((65'd1 << W) - 65'd1);
  state_t state, state_n;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [W-1:0] distance, minute;
  logic fare_valid, night_q, idle_n, p_hit, t_hit, p_wrap, t_wrap;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = bus.start ? (bus.halted ? WAIT : DRIVE) : IDLE;
    else if (state == DONE) state_n = bus.clear ? IDLE : DONE;
    else state_n = bus.stop ? DONE : (bus.halted ? WAIT : DRIVE);
  end
  assign idle_n = state_n == IDLE;
  assign p_hit = (state == DRIVE || state == WAIT) && bus.wheel_pulse;
  assign t_hit = state == WAIT && bus.sec_tick;
  assign p_wrap = pcnt == PW'(PULSES_PER_UNIT - 1);
  assign t_wrap = tcnt == TW'(TICKS_PER_MIN - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pcnt <= '0;
      tcnt <= '0;
      distance <= '0;
      minute <= '0;
      fare_valid <= 1'b0;
    end else begin
      state <= state_n;
      // The fare settles one edge after DONE is entered, so valid trails the state by one cycle.
      fare_valid <= state == DONE && state_n == DONE;
      if (idle_n) begin
        pcnt <= '0;
        tcnt <= '0;
        distance <= '0;
        minute <= '0;
      end else begin
        if (p_hit) pcnt <= p_wrap ? '0 : pcnt + PW'(1);
        if (p_hit && p_wrap) distance <= W'(sat_add(64'(distance), 64'd1, MAX));
        if (t_hit) tcnt <= t_wrap ? '0 : tcnt + TW'(1);
        if (t_hit && t_wrap) minute <= W'(sat_add(64'(minute), 64'd1, MAX));
      end
    end
`ifdef TAXI_NIGHT_SURCHARGE_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) night_q <= 1'b0;
    else if (state == IDLE && bus.start) night_q <= bus.night;
`else
  assign night_q = 1'b0;
`endif
  taxi_fare_calc #(
    .W(W), .BASE_FARE(BASE_FARE), .BASE_DIST(BASE_DIST), .KM_RATE(KM_RATE), .WAIT_RATE(WAIT_RATE)
  ) u_fare (
    .clk(clk), .rst_n(rst_n), .clr(idle_n), .night(night_q),
    .distance(distance), .minute(minute), .fare(bus.fare)
  );
  assign bus.distance = distance;
  assign bus.minute = minute;
  assign bus.state = state;
  assign bus.fare_valid = fare_valid;
endmodule

// File: tb/tb_taxi_meter_core.sv
// tb_taxi_meter_core: directed trips with hand-computed fares; a second W=8 instance covers saturation
module tb_taxi_meter_core;
  import taxi_meter_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  taxi_meter_if #(.W(16)) ifa();
  taxi_meter_if #(.W(8)) ifs();
  taxi_meter_core #(.W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(ifa));
  taxi_meter_core #(.W(8), .TICKS_PER_MIN(1)) u_sat (.clk(clk), .rst_n(rst_n), .bus(ifs));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic h);
    ifa.halted = h;
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
  endtask
  task automatic pulses(input int n);
    ifa.wheel_pulse = 1'b1;
    repeat (n) step();
    ifa.wheel_pulse = 1'b0;
  endtask
  task automatic ticks(input int n);
    ifa.sec_tick = 1'b1;
    repeat (n) step();
    ifa.sec_tick = 1'b0;
  endtask
  task automatic do_stop();
    ifa.stop = 1'b1;
    step();
    ifa.stop = 1'b0;
    step();
  endtask
  task automatic do_clear();
    ifa.clear = 1'b1;
    step();
    ifa.clear = 1'b0;
  endtask
  task automatic check_trip(input string tag, input int d, input int m, input int f, input int st, input int v);
    check({tag, "_dist"}, 32'(ifa.distance), 32'(d));
    check({tag, "_min"}, 32'(ifa.minute), 32'(m));
    check({tag, "_fare"}, 32'(ifa.fare), 32'(f));
    check({tag, "_state"}, 32'(ifa.state), 32'(st));
    check({tag, "_valid"}, 32'(ifa.fare_valid), 32'(v));
  endtask
  initial begin
    {ifa.start, ifa.stop, ifa.clear, ifa.halted, ifa.wheel_pulse, ifa.sec_tick} = '0;
    {ifs.start, ifs.stop, ifs.clear, ifs.halted, ifs.wheel_pulse, ifs.sec_tick} = '0;
`ifdef TAXI_NIGHT_SURCHARGE_EN
    ifa.night = 1'b0;
    ifs.night = 1'b0;
`endif
    #2 rst_n = 1'b0;
    step();
    step();
    check_trip("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    // short trip: 20 pulses driving, 120 s waiting
    do_start(1'b0);
    check("short_drive", 32'(ifa.state), 32'd1);
    pulses(20);
    ifa.halted = 1'b1;
    step();
    check("short_wait", 32'(ifa.state), 32'd2);
    ticks(120);
    ifa.halted = 1'b0;
    ifa.stop = 1'b1;
    step();
    ifa.stop = 1'b0;
    check("short_done_early", 32'(ifa.state), 32'd3);
    check("short_valid_early", 32'(ifa.fare_valid), 32'd0);
    step();
    check_trip("short", 2, 2, 7, 3, 1);
    do_clear();
    check_trip("clear1", 0, 0, 0, 0, 0);
    // long trip, including the one-cycle fare lag
    do_start(1'b0);
    pulses(50);
    check("long_lag_dist", 32'(ifa.distance), 32'd5);
    check("long_lag_fare", 32'(ifa.fare), 32'd7);
    do_stop();
    check_trip("long", 5, 0, 9, 3, 1);
    do_clear();
    check_trip("clear2", 0, 0, 0, 0, 0);
    // branch boundary
    do_start(1'b0);
    pulses(30);
    do_stop();
    check_trip("b30", 3, 0, 5, 3, 1);
    do_clear();
    do_start(1'b0);
    pulses(29);
    do_stop();
    check_trip("b29", 2, 0, 5, 3, 1);
    do_clear();
    // stop coincident with the 10th pulse, then DONE ignores everything but clear
    do_start(1'b0);
    pulses(9);
    ifa.wheel_pulse = 1'b1;
    ifa.stop = 1'b1;
    step();
    {ifa.wheel_pulse, ifa.stop} = '0;
    check("sim_state", 32'(ifa.state), 32'd3);
    check("sim_dist", 32'(ifa.distance), 32'd1);
    pulses(15);
    ifa.halted = 1'b1;
    ticks(120);
    do_start(1'b1);
    check_trip("sim_frozen", 1, 0, 5, 3, 1);
    ifa.halted = 1'b0;
    do_clear();
    // tick prescaler holds through DRIVE
    do_start(1'b1);
    ticks(30);
    ifa.halted = 1'b0;
    step();
    ticks(50);
    check("hold_drive_min", 32'(ifa.minute), 32'd0);
    ifa.halted = 1'b1;
    step();
    ticks(30);
    check("hold_min", 32'(ifa.minute), 32'd1);
    ifa.halted = 1'b0;
    do_stop();
    do_clear();
    // asynchronous reset in WAIT
    do_start(1'b1);
    check("rst_wait", 32'(ifa.state), 32'd2);
    ticks(70);
    pulses(15);
    step();
    check("rst_pre_fare", 32'(ifa.fare), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check_trip("async_rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    do_start(1'b0);
    pulses(5);
    check("rst_presc_5", 32'(ifa.distance), 32'd0);
    pulses(5);
    ifa.halted = 1'b1;
    step();
    ticks(50);
    check("rst_tick_presc", 32'(ifa.minute), 32'd0);
    ifa.halted = 1'b0;
    do_stop();
    check_trip("rst_fresh", 1, 0, 5, 3, 1);
    do_clear();
`ifdef TAXI_NIGHT_SURCHARGE_EN
    ifa.night = 1'b1;
    do_start(1'b0);
    ifa.night = 1'b0;
    pulses(50);
    do_stop();
    check_trip("night", 5, 0, 13, 3, 1);
    do_clear();
`endif
    // saturation on the W=8, one-tick-per-minute instance
    ifs.halted = 1'b1;
    ifs.start = 1'b1;
    step();
    ifs.start = 1'b0;
    check("sat_wait", 32'(ifs.state), 32'd2);
    ifs.sec_tick = 1'b1;
    repeat (250) step();
    ifs.sec_tick = 1'b0;
    step();
    check("sat_min250", 32'(ifs.minute), 32'd250);
    check("sat_fare_edge", 32'(ifs.fare), 32'd255);
    ifs.sec_tick = 1'b1;
    repeat (10) step();
    ifs.sec_tick = 1'b0;
    ifs.stop = 1'b1;
    step();
    ifs.stop = 1'b0;
    step();
    check("sat_min", 32'(ifs.minute), 32'd255);
    check("sat_fare", 32'(ifs.fare), 32'd255);
    check("sat_valid", 32'(ifs.fare_valid), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
